// File: rtl/boot_rom_arbiter.sv
// boot_rom_arbiter
//   Shares one synchronous-read boot ROM (1 cycle latency) between the CPU
//   instruction-fetch port (I) and data port (D). Round-robin arbitration,
//   one buffered response per port, and a sticky post-boot lock that turns
//   every later access into an error without touching the ROM.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_req_valid/addr, i_req_ready   I request handshake (byte address)
//   i_rsp_valid/data/err, i_rsp_ready  I response handshake
//   d_req_* / d_rsp_*               same for the D port
//   lock_req                        pulse: seal the ROM until reset
//   locked                          current lock state
//   rom_addr                        word address to ROM (0 when idle/error)
//   rom_rdata                       ROM data, valid the cycle after rom_addr
module boot_rom_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  input  logic [31:0]       i_req_addr,
  output logic              i_req_ready,
  output logic              i_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] i_rsp_data,
  output logic              i_rsp_err,
  input  logic              d_req_valid,
  input  logic [31:0]       d_req_addr,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              d_rsp_err,
  input  logic              lock_req,
  output logic              locked,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata
);

  localparam int NP = 2;
  localparam int PI = 0;
  localparam int PD = 1;

  logic [NP-1:0] req_valid;
  logic [NP-1:0] rsp_ready;
  logic [31:0]   req_addr [NP];
  logic [NP-1:0] eligible;
  logic [NP-1:0] cand;
  logic [NP-1:0] grant;
  logic [NP-1:0] req_err;

  logic              pend_reg      [NP];
  logic              pend_err_reg  [NP];
  logic              rsp_valid_reg [NP];
  logic              rsp_err_reg   [NP];
  logic [DATA_W-1:0] rsp_data_reg  [NP];
  logic              locked_reg;
  logic              last_grant_reg;  // 1 = D granted last, 0 = I

  assign req_valid[PI] = i_req_valid;
  assign req_valid[PD] = d_req_valid;
  assign rsp_ready[PI] = i_rsp_ready;
  assign rsp_ready[PD] = d_rsp_ready;
  assign req_addr[PI]  = i_req_addr;
  assign req_addr[PD]  = d_req_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_port
      // A port may accept only when nothing is in flight and its buffer is
      // empty or being drained this cycle.
      assign eligible[gi] = !pend_reg[gi] && (!rsp_valid_reg[gi] || rsp_ready[gi]);
      assign cand[gi]     = req_valid[gi] && eligible[gi];
      // Anything outside the 4 KiB window, misaligned, or after lock errors.
      assign req_err[gi]  = locked_reg
                            || (req_addr[gi][31:ADDR_W+2] != '0)
                            || (req_addr[gi][1:0] != 2'b00);
    end
  endgenerate

  // On a tie the port that did not win last time gets the ROM.
  assign grant[PI] = cand[PI] && (!cand[PD] || last_grant_reg);
  assign grant[PD] = cand[PD] && (!cand[PI] || !last_grant_reg);

  always_comb begin
    rom_addr = '0;
    for (int p = 0; p < NP; p++) begin
      if (grant[p] && !req_err[p]) begin
        rom_addr = req_addr[p][ADDR_W+1:2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
      for (int p = 0; p < NP; p++) begin
        pend_reg[p]      <= 1'b0;
        pend_err_reg[p]  <= 1'b0;
        rsp_valid_reg[p] <= 1'b0;
        rsp_err_reg[p]   <= 1'b0;
        rsp_data_reg[p]  <= '0;
      end
    end else begin
      locked_reg <= locked_reg | lock_req;
      if (|grant) begin
        last_grant_reg <= grant[PD];
      end
      for (int p = 0; p < NP; p++) begin
        if (pend_reg[p]) begin
          // Capture overrides a simultaneous pop: the buffer refills.
          rsp_valid_reg[p] <= 1'b1;
          rsp_data_reg[p]  <= pend_err_reg[p] ? '0 : rom_rdata;
          rsp_err_reg[p]   <= pend_err_reg[p];
          pend_reg[p]      <= 1'b0;
        end else begin
          if (rsp_valid_reg[p] && rsp_ready[p]) begin
            rsp_valid_reg[p] <= 1'b0;
          end
          if (grant[p]) begin
            pend_reg[p]     <= 1'b1;
            pend_err_reg[p] <= req_err[p];
          end
        end
      end
    end
  end

  assign i_req_ready = grant[PI];
  assign d_req_ready = grant[PD];
  assign i_rsp_valid = rsp_valid_reg[PI];
  assign d_rsp_valid = rsp_valid_reg[PD];
  assign i_rsp_data  = rsp_data_reg[PI];
  assign d_rsp_data  = rsp_data_reg[PD];
  assign i_rsp_err   = rsp_err_reg[PI];
  assign d_rsp_err   = rsp_err_reg[PD];
  assign locked      = locked_reg;

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// tb_boot_rom_arbiter
//   Directed bench for boot_rom_arbiter. A behavioural ROM answers rom_addr
//   one cycle later. A negedge monitor pushes expected responses on every
//   request handshake, pops/compares on every response handshake, checks
//   the 2-cycle latency and the ROM address of every cycle.
module tb_boot_rom_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              i_req_valid, d_req_valid;
  logic [31:0]       i_req_addr, d_req_addr;
  logic              i_req_ready, d_req_ready;
  logic              i_rsp_valid, d_rsp_valid;
  logic              i_rsp_ready, d_rsp_ready;
  logic [DATA_W-1:0] i_rsp_data, d_rsp_data;
  logic              i_rsp_err, d_rsp_err;
  logic              lock_req;
  logic              locked;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rdata;

  int checks   = 0;
  int failures = 0;

  boot_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
    .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .lock_req(lock_req), .locked(locked),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [9:0] idx);
    return 32'hC0DE_0000 ^ {idx, 2'b00, idx, 2'b11, 8'h5A};
  endfunction

  // ROM: synchronous read, one cycle latency
  always @(posedge clk) rom_rdata <= rom_word(rom_addr);

  function automatic logic [32:0] exp_rsp(input logic [31:0] a, input logic lk);
    logic e;
    e = lk || (a[31:12] != 20'd0) || (a[1:0] != 2'b00);
    return e ? {1'b1, 32'h0} : {1'b0, rom_word(a[11:2])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    i_req_addr  = 32'h0; d_req_addr  = 32'h0;
    lock_req    = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [32:0] q_i[$];
  logic [32:0] q_d[$];

  initial begin
    int cnt_i;
    int cnt_d;
    logic mlock;
    logic [32:0] e;
    logic [ADDR_W-1:0] era;
    cnt_i = 0; cnt_d = 0; mlock = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q_i.delete(); q_d.delete();
        cnt_i = 0; cnt_d = 0; mlock = 1'b0;
      end else begin
        if (cnt_i == 2) begin
          chk("i_lat_c2", i_rsp_valid, 1); cnt_i = 0;
        end else if (cnt_i == 1) begin
          chk("i_lat_c1", i_rsp_valid, 0); cnt_i = 2;
        end
        if (cnt_d == 2) begin
          chk("d_lat_c2", d_rsp_valid, 1); cnt_d = 0;
        end else if (cnt_d == 1) begin
          chk("d_lat_c1", d_rsp_valid, 0); cnt_d = 2;
        end
        if (i_rsp_valid && i_rsp_ready) begin
          chk("i_rsp_expected", q_i.size() > 0, 1);
          if (q_i.size() > 0) begin
            e = q_i.pop_front();
            chk("i_rsp_data", i_rsp_data, e[31:0]);
            chk("i_rsp_err", i_rsp_err, e[32]);
          end
        end
        if (d_rsp_valid && d_rsp_ready) begin
          chk("d_rsp_expected", q_d.size() > 0, 1);
          if (q_d.size() > 0) begin
            e = q_d.pop_front();
            chk("d_rsp_data", d_rsp_data, e[31:0]);
            chk("d_rsp_err", d_rsp_err, e[32]);
          end
        end
        chk("one_grant", i_req_ready & d_req_ready, 0);
        era = '0;
        if (i_req_valid && i_req_ready) begin
          e = exp_rsp(i_req_addr, mlock);
          q_i.push_back(e); cnt_i = 1;
          if (!e[32]) era = i_req_addr[11:2];
        end
        if (d_req_valid && d_req_ready) begin
          e = exp_rsp(d_req_addr, mlock);
          q_d.push_back(e); cnt_d = 1;
          if (!e[32]) era = d_req_addr[11:2];
        end
        chk("rom_addr", rom_addr, era);
        if (lock_req) mlock = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int icnt;
    rst_n = 1'b0;
    idle_inputs();
    i_rsp_ready = 1'b0; d_rsp_ready = 1'b0;

    // Reset with random inputs: buffers and lock stay cleared
    for (int k = 0; k < 5; k++) begin
      cyc();
      i_req_valid = 1'($urandom); d_req_valid = 1'($urandom);
      i_req_addr  = $urandom;     d_req_addr  = $urandom;
      i_rsp_ready = 1'($urandom); d_rsp_ready = 1'($urandom);
      lock_req    = 1'($urandom);
      @(negedge clk);
      chk("rst_i_rsp_valid", i_rsp_valid, 0);
      chk("rst_i_rsp_data", i_rsp_data, 0);
      chk("rst_i_rsp_err", i_rsp_err, 0);
      chk("rst_d_rsp_valid", d_rsp_valid, 0);
      chk("rst_d_rsp_data", d_rsp_data, 0);
      chk("rst_d_rsp_err", d_rsp_err, 0);
      chk("rst_locked", locked, 0);
    end
    cyc();
    idle_inputs();
    i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
    rst_n = 1'b1;
    $display("step reset_idle done");

    // First read: I at 0x10
    cyc();
    i_req_valid = 1'b1; i_req_addr = 32'h0000_0010;
    @(negedge clk);
    chk("rd_ready", i_req_ready, 1);
    chk("rd_rom_addr", rom_addr, 4);
    cyc();
    i_req_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("rd_rsp_valid", i_rsp_valid, 1);
    chk("rd_rsp_data", i_rsp_data, rom_word(10'd4));
    chk("rd_rsp_err", i_rsp_err, 0);
    $display("step first_read done");

    // Round robin from a fresh reset: I wins the first tie
    cyc(); rst_n = 1'b0; idle_inputs();
    cyc(); rst_n = 1'b1;
    cyc();
    i_req_valid = 1'b1; i_req_addr = 32'h0;
    d_req_valid = 1'b1; d_req_addr = 32'h4;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_i_ready", i_req_ready, (k % 2) == 0);
      chk("rr_d_ready", d_req_ready, (k % 2) == 1);
      cyc();
    end
    idle_inputs();
    repeat (3) cyc();
    $display("step round_robin done");

    // Backpressure on D while I keeps being served
    d_rsp_ready = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h0000_0020;
    @(negedge clk);
    chk("bp_d_accept", d_req_ready, 1);
    cyc();
    d_req_addr = 32'h0000_0024;
    i_req_valid = 1'b1; i_req_addr = 32'h0000_0030;
    @(negedge clk);
    chk("bp_d_busy", d_req_ready, 0);
    cyc();
    icnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_d_rsp_valid", d_rsp_valid, 1);
      chk("bp_d_rsp_data", d_rsp_data, rom_word(10'd8));
      chk("bp_d_req_ready", d_req_ready, 0);
      if (i_req_ready) icnt++;
      cyc();
    end
    chk("bp_i_served", icnt >= 2, 1);
    d_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_accept", d_req_ready, 1);
    chk("bp_pop_valid", d_rsp_valid, 1);
    cyc();
    idle_inputs();
    repeat (4) cyc();
    $display("step backpressure done");

    // Address errors
    i_req_valid = 1'b1; i_req_addr = 32'h0000_1000;
    @(negedge clk);
    chk("err_i_ready", i_req_ready, 1);
    chk("err_i_rom_addr", rom_addr, 0);
    cyc();
    i_req_valid = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h0000_0002;
    @(negedge clk);
    chk("err_d_ready", d_req_ready, 1);
    chk("err_d_rom_addr", rom_addr, 0);
    cyc();
    d_req_valid = 1'b0;
    @(negedge clk);
    chk("err_i_rsp_valid", i_rsp_valid, 1);
    chk("err_i_rsp_err", i_rsp_err, 1);
    chk("err_i_rsp_data", i_rsp_data, 0);
    cyc();
    @(negedge clk);
    chk("err_d_rsp_valid", d_rsp_valid, 1);
    chk("err_d_rsp_err", d_rsp_err, 1);
    chk("err_d_rsp_data", d_rsp_data, 0);
    repeat (2) cyc();
    $display("step errors done");

    // Lock pulse together with an accepted request
    i_req_valid = 1'b1; i_req_addr = 32'h0000_0008; lock_req = 1'b1;
    @(negedge clk);
    chk("lk_locked_before", locked, 0);
    chk("lk_ready", i_req_ready, 1);
    chk("lk_rom_addr", rom_addr, 2);
    cyc();
    i_req_valid = 1'b0; lock_req = 1'b0;
    @(negedge clk);
    chk("lk_locked_after", locked, 1);
    cyc();
    @(negedge clk);
    chk("lk_rsp_valid", i_rsp_valid, 1);
    chk("lk_rsp_data", i_rsp_data, rom_word(10'd2));
    chk("lk_rsp_err", i_rsp_err, 0);
    cyc();
    i_req_valid = 1'b1; i_req_addr = 32'h0000_000C;
    @(negedge clk);
    chk("lk2_ready", i_req_ready, 1);
    chk("lk2_rom_addr", rom_addr, 0);
    cyc();
    i_req_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("lk2_rsp_err", i_rsp_err, 1);
    chk("lk2_rsp_data", i_rsp_data, 0);
    repeat (5) cyc();
    chk("lk_sticky", locked, 1);
    $display("step lock done");

    // Reset while I is in flight and D holds an unpopped response
    d_rsp_ready = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h0000_0040;
    cyc();
    d_req_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("mid_d_held", d_rsp_valid, 1);
    cyc();
    i_req_valid = 1'b1; i_req_addr = 32'h0000_0044;
    @(negedge clk);
    chk("mid_i_accept", i_req_ready, 1);
    cyc();
    i_req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_d_rsp_valid", d_rsp_valid, 0);
    chk("mid_d_rsp_data", d_rsp_data, 0);
    chk("mid_i_rsp_valid", i_rsp_valid, 0);
    chk("mid_locked", locked, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    d_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_i_rsp_valid", i_rsp_valid, 0);
      chk("post_d_rsp_valid", d_rsp_valid, 0);
      cyc();
    end
    $display("step reset_mid_op done");

    chk("end_q_i_empty", q_i.size(), 0);
    chk("end_q_d_empty", q_d.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
